pipe_hazard_scoreboard: RTL

//  Parametrised hazard/forwarding unit for the in-order pipelined core (IF/ID/EX/MA/WB family).

---
 rtl/pipe_pkg.sv | 32 +++
 rtl/pipe_hazard_scoreboard_if.sv | 48 ++++
 rtl/sb_src_match.sv | 46 ++++
 rtl/pipe_hazard_scoreboard.sv | 116 +++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
//   Shared types and constants for the in-order IF/ID/EX/MA/WB core.
//   - sb_entry_t : one in-flight register write tracked by the hazard
//                  scoreboard {valid, rdst, is_load}. rdst is sized for the
//                  largest register file the core family uses (RW_MAX bits);
//                  narrower register numbers are zero-extended into it.
//   - FWD_RF     : forwarding select meaning "use the ID/EX register value".
//   - OP_*       : primary opcode values shared by decode and the benches.
//   Configuration macro read by users of this package: PIPE_HAZARD_FWD_EN.
// ----------------------------------------------------------------------------
package pipe_pkg;

    localparam int RW_MAX = 8;

    typedef struct packed {
        logic              valid;
        logic [RW_MAX-1:0] rdst;
        logic              is_load;
    } sb_entry_t;

    localparam int FWD_RF = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

endpackage

// File: rtl/pipe_hazard_scoreboard_if.sv
// ----------------------------------------------------------------------------
// pipe_hazard_scoreboard_if
//   Bundle between the ID stage / branch unit and the hazard scoreboard.
//   master : ID stage side; drives the decoded instruction and flush, reads
//            stall/issue/forwarding selects and the stall counter.
//   slave  : the scoreboard.
//   Signals
//     id_valid, id_rs, id_rt, id_rs_use, id_rt_use, id_rdst, id_we,
//     id_is_load, flush                     master -> slave
//     stall, issue, ex_fwd_rs, ex_fwd_rt,
//     stall_cnt                             slave  -> master
// ----------------------------------------------------------------------------
interface pipe_hazard_scoreboard_if #(
    parameter int NREG  = 32,
    parameter int DEPTH = 3,
    parameter int CNTW  = 32
);
    localparam int RW  = $clog2(NREG);
    localparam int FSW = $clog2(DEPTH + 1);

    logic            id_valid;
    logic [RW-1:0]   id_rs;
    logic [RW-1:0]   id_rt;
    logic            id_rs_use;
    logic            id_rt_use;
    logic [RW-1:0]   id_rdst;
    logic            id_we;
    logic            id_is_load;
    logic            flush;
    logic            stall;
    logic            issue;
    logic [FSW-1:0]  ex_fwd_rs;
    logic [FSW-1:0]  ex_fwd_rt;
    logic [CNTW-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_rs_use, id_rt_use,
               id_rdst, id_we, id_is_load, flush,
        input  stall, issue, ex_fwd_rs, ex_fwd_rt, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_rs_use, id_rt_use,
               id_rdst, id_we, id_is_load, flush,
        output stall, issue, ex_fwd_rs, ex_fwd_rt, stall_cnt
    );

endinterface

// File: rtl/sb_src_match.sv
// ----------------------------------------------------------------------------
// sb_src_match
//   Looks up one ID-stage source register in the scoreboard and reports the
//   youngest in-flight producer of it.
//   Ports
//     ents     in   scoreboard entries, index 0 = EX ... DEPTH-1 = WB
//     src_reg  in   source register number
//     src_use  in   the instruction actually reads src_reg
//     hit      out  a producer exists in EX..(WB-1)
//     stage    out  entry index of the youngest producer (valid when hit)
//     is_load  out  that producer's value comes from data memory
//   The WB entry is never searched: the register file writes on the falling
//   edge, so ID already reads the value being written back.
// ----------------------------------------------------------------------------
module sb_src_match
    import pipe_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int RW    = 5,
    parameter int SW    = 2
) (
    input  sb_entry_t        ents [DEPTH],
    input  logic [RW-1:0]    src_reg,
    input  logic             src_use,
    output logic             hit,
    output logic [SW-1:0]    stage,
    output logic             is_load
);

    always_comb begin
        hit     = 1'b0;
        stage   = '0;
        is_load = 1'b0;
        if (src_use && (src_reg != '0)) begin
            // Oldest first so that a younger match overrides an older one.
            for (int k = DEPTH - 2; k >= 0; k--) begin
                if (ents[k].valid && (ents[k].rdst == RW_MAX'(src_reg))) begin
                    hit     = 1'b1;
                    stage   = SW'(k);
                    is_load = ents[k].is_load;
                end
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_scoreboard.sv
// ----------------------------------------------------------------------------
// pipe_hazard_scoreboard
//   Hazard / forwarding unit for the in-order pipelined core. Tracks in-flight
//   register writes from EX to WB and produces the ID-stage stall, the issue
//   qualifier and registered EX-stage forwarding selects, replacing NOP
//   padding in the instruction stream.
//   Configuration macro: PIPE_HAZARD_FWD_EN
//     defined   : ALU results forwarded with no stall; a load stalls only
//                 while its data is not yet in a forwardable register
//                 (stage index + 1 < LD_FWD).
//     undefined : no forwarding; ID stalls until every producer it depends
//                 on has reached WB.
//   Ports
//     CLK    in  clock, rising edge
//     RST_X  in  asynchronous active-low reset
//     sb_if  slave modport of pipe_hazard_scoreboard_if (ID inputs, flush,
//            stall, issue, ex_fwd_rs/rt, stall_cnt)
// ----------------------------------------------------------------------------
module pipe_hazard_scoreboard
    import pipe_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int DEPTH  = 3,
    parameter int LD_FWD = 2,
    parameter int CNTW   = 32
) (
    input  logic                    CLK,
    input  logic                    RST_X,
    pipe_hazard_scoreboard_if.slave sb_if
);

    localparam int RW  = $clog2(NREG);
    localparam int FSW = $clog2(DEPTH + 1);

    sb_entry_t       sb_p [DEPTH];
    logic            hit_rs, hit_rt;
    logic [FSW-1:0]  stg_rs, stg_rt;
    logic            ld_rs, ld_rt;
    logic            hz_rs, hz_rt;
    logic [FSW-1:0]  fwd_rs_c, fwd_rt_c;
    logic            stall_c, issue_c;
    logic [FSW-1:0]  fwd_rs_p1, fwd_rt_p1;
    logic [CNTW-1:0] stall_cnt_p1;

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    sb_src_match #(.DEPTH(DEPTH), .RW(RW), .SW(FSW)) u_match_rs (
        .ents    (sb_p),
        .src_reg (sb_if.id_rs),
        .src_use (sb_if.id_rs_use),
        .hit     (hit_rs),
        .stage   (stg_rs),
        .is_load (ld_rs)
    );

    sb_src_match #(.DEPTH(DEPTH), .RW(RW), .SW(FSW)) u_match_rt (
        .ents    (sb_p),
        .src_reg (sb_if.id_rt),
        .src_use (sb_if.id_rt_use),
        .hit     (hit_rt),
        .stage   (stg_rt),
        .is_load (ld_rt)
    );

`ifdef PIPE_HAZARD_FWD_EN
    // A load still short of the first register that holds its data must wait;
    // anything else found in flight is taken from pipeline register k+1.
    always_comb begin
        hz_rs    = hit_rs && ld_rs && ((int'(stg_rs) + 1) < LD_FWD);
        hz_rt    = hit_rt && ld_rt && ((int'(stg_rt) + 1) < LD_FWD);
        fwd_rs_c = (hit_rs && !hz_rs) ? stg_rs + 1'b1 : FSW'(FWD_RF);
        fwd_rt_c = (hit_rt && !hz_rt) ? stg_rt + 1'b1 : FSW'(FWD_RF);
    end
`else
    logic unused_cfg;
    assign unused_cfg = ld_rs ^ ld_rt ^ (LD_FWD != 0) ^ (|stg_rs) ^ (|stg_rt);
    always_comb begin
        hz_rs    = hit_rs;
        hz_rt    = hit_rt;
        fwd_rs_c = FSW'(FWD_RF);
        fwd_rt_c = FSW'(FWD_RF);
    end
`endif

    // A resolved branch kills the ID instruction, so nothing is worth waiting
    // for; reset also forces issue low while RST_X is held.
    assign stall_c = (hz_rs || hz_rt) && !sb_if.flush;
    assign issue_c = RST_X && sb_if.id_valid && !stall_c && !sb_if.flush;

    // ---- ID -> EX boundary: scoreboard shift and EX forwarding selects ----
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            for (int k = 0; k < DEPTH; k++) sb_p[k] <= '0;
            fwd_rs_p1    <= '0;
            fwd_rt_p1    <= '0;
            stall_cnt_p1 <= '0;
        end else begin
            sb_p[0] <= '{valid:   issue_c && sb_if.id_we && (sb_if.id_rdst != '0),
                         rdst:    RW_MAX'(sb_if.id_rdst),
                         is_load: sb_if.id_is_load};
            for (int k = 1; k < DEPTH; k++) sb_p[k] <= sb_p[k-1];
            fwd_rs_p1 <= issue_c ? fwd_rs_c : '0;
            fwd_rt_p1 <= issue_c ? fwd_rt_c : '0;
            if (stall_c) stall_cnt_p1 <= sat_inc(stall_cnt_p1);
        end
    end

    assign sb_if.stall     = stall_c;
    assign sb_if.issue     = issue_c;
    assign sb_if.ex_fwd_rs = fwd_rs_p1;
    assign sb_if.ex_fwd_rt = fwd_rt_p1;
    assign sb_if.stall_cnt = stall_cnt_p1;

endmodule
